mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised multi-cycle load/store unit between the CPU datapath and the memory/IO bus. It accepts one load or store per transaction and drives a word-aligned bus request with byte enables. It waits on the bus ready handshake with a timeout, then returns sign- or zero-extended read data plus an error code. It stalls the core while a transaction is in flight, replacing the single-cycle direct data-memory connection.

## Interface
- XLEN, default 32: data/address width; legal values 32 or 64.
- TIMEOUT, default 16: maximum BUS-state cycles without bus_ready before an abort; must be ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU requests an access; held high while stall is high.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  access type, DM_* code.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- stall  out  1  CPU must not advance.
- rsp_valid  out  1  one-cycle pulse: transaction finished.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  2  ERR_NONE / ERR_MISALIGN / ERR_TIMEOUT / ERR_TYPE.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  XLEN  req_addr with low LB bits cleared, where LB = log2(XLEN/8).
- bus_be  out  XLEN/8  byte enables.
- bus_wdata  out  XLEN  lane-positioned store data.
- bus_rdata  in  XLEN  full bus word.
- bus_ready  in  1  bus completes the current request.

## Operation
- DM codes: DM_WORD=000, DM_HALF=001, DM_HALF_U=010, DM_BYTE=011, DM_BYTE_U=100, DM_DWORD=101.
- DM_DWORD is legal only when XLEN=64. Any other code is ERR_TYPE.
- Access size: 1, 2, 4 or 8 bytes. off = req_addr[LB-1:0].
- A request is misaligned when off is not a multiple of the size.
- Store lanes:
  - bus_be = ((1<<size)-1) << off.
  - bus_wdata = req_wdata replicated across lanes, so the selected lanes carry the low size bytes.
- Load data:
  - Take (bus_rdata >> 8*off), keep the low size bytes.
  - Sign-extend for DM_HALF, DM_BYTE and DM_WORD when XLEN=64; zero-extend for _U types.
- FSM states and transitions:
  - IDLE, with req_valid high:
    - ERR_TYPE or ERR_MISALIGN detected → RESP; no bus activity.
    - Otherwise latch all bus outputs → BUS; counter cleared.
  - BUS: bus_req held high, outputs stable.
    - bus_ready high → capture extended rdata → RESP, rsp_err = ERR_NONE.
    - Counter reaches TIMEOUT-1 without ready → RESP, rsp_err = ERR_TIMEOUT; bus_req drops on the next edge.
  - RESP: rsp_valid=1 for exactly one cycle → IDLE.
- stall = req_valid & ~rsp_valid (combinational).
- bus_ready outside BUS is ignored.

## Timing
- Reset: state=IDLE, counter=0. All outputs 0: bus_req, bus_we, bus_be, bus_addr, bus_wdata, rsp_valid, rsp_rdata, rsp_err.
- Reset asserted mid-transaction: bus_req falls immediately (asynchronously); no rsp_valid pulse.
- Request accepted at edge N: bus_req high after N.
- Zero-wait bus (bus_ready high in the first BUS cycle): rsp_valid high in the cycle after N+1. Total latency 3 cycles, stall high for 2 cycles.
- Error path: rsp_valid in the cycle after N; latency 2.
- Timeout: exactly TIMEOUT BUS cycles, then the RESP cycle.
- bus_ready and timeout in the same cycle: ready wins, ERR_NONE.
- Back-to-back: a req_valid held high into IDLE after RESP is accepted at that edge. Maximum throughput is one access per 3 cycles.
- rsp_rdata and rsp_err are valid only while rsp_valid is high. They hold their value until the next RESP.

## Structure
- Package mem_lsu_pkg holds:
  - DM_* codes and ERR_* codes;
  - the state encoding (IDLE=0, BUS=1, RESP=2);
  - a size_of(type) function.
- Sub-module mem_lsu_lane (combinational, parametrised by XLEN) computes:
  - size, misalign and illegal-type flags;
  - bus_be and bus_wdata;
  - the extracted, extended load data.
- mem_lsu holds the FSM, timeout counter and output registers.

## Test plan
- XLEN=32, sb, addr=0x1003, wdata=0x000000AB, bus_ready high in the first BUS cycle:
  - bus_addr=0x1000, bus_be=1000, bus_wdata=0xABABABAB;
  - rsp_valid in cycle 3, rsp_err=0.
- lh at 0x2002 with bus_rdata=0x8001_1234 → rsp_rdata=0xFFFF8001. lhu at the same address → 0x00008001.
- lw at 0x3002 → rsp_err=ERR_MISALIGN one cycle after acceptance; bus_req never asserted.
- TIMEOUT=4, bus_ready held low:
  - bus_req high for exactly 4 cycles, then rsp_err=ERR_TIMEOUT, rsp_rdata=0.
  - Repeat with ready in the 4th cycle → ERR_NONE.
- XLEN=32 with req_type=DM_DWORD → ERR_TYPE. XLEN=64, ld at 0x8 → bus_be=0xFF, full word returned.
- rst pulled low while in BUS → bus_req=0 immediately, no rsp_valid. After release, a new lw at 0x10 completes normally.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: access types, error codes, FSM states
// and the helpers that map an access type to its size and legality.
package mem_lsu_pkg;

    typedef enum logic [2:0] {
        DM_WORD   = 3'b000,
        DM_HALF   = 3'b001,
        DM_HALF_U = 3'b010,
        DM_BYTE   = 3'b011,
        DM_BYTE_U = 3'b100,
        DM_DWORD  = 3'b101
    } dm_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_TYPE     = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Illegal codes report size 1 so downstream lane math stays in range.
    function automatic logic [3:0] size_of(input logic [2:0] t);
        logic [3:0] s;
        case (t)
            DM_WORD:            s = 4'd4;
            DM_HALF, DM_HALF_U: s = 4'd2;
            DM_DWORD:           s = 4'd8;
            default:            s = 4'd1;
        endcase
        return s;
    endfunction

    function automatic logic type_legal(input logic [2:0] t, input int xlen);
        return (t <= DM_BYTE_U) || ((t == DM_DWORD) && (xlen == 64));
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Word-aligned memory/IO bus between the load/store unit (master) and the memory
// system (slave): one request held until ready, with byte enables.
interface mem_lsu_if #(
    parameter int XLEN = 32
);
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   rdata;
    logic              ready;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/mem_lsu_lane.sv
// Combinational byte-lane logic: request checks and store lane placement from the
// incoming request, and load extraction/extension from the latched access.
module mem_lsu_lane
    import mem_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                req_type,
    input  logic [$clog2(XLEN/8)-1:0] req_off,
    input  logic [XLEN-1:0]           req_wdata,
    input  logic [2:0]                ld_type,
    input  logic [$clog2(XLEN/8)-1:0] ld_off,
    input  logic [XLEN-1:0]           rdata,
    output logic                      illegal,
    output logic                      misalign,
    output logic [XLEN/8-1:0]         be,
    output logic [XLEN-1:0]           wdata,
    output logic [XLEN-1:0]           ld_data
);
    localparam int NB = XLEN / 8;

    logic [3:0]      st_size;
    logic [3:0]      ld_size;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep_mask;
    logic            sign_bit;
    logic            do_sext;

    assign st_size  = size_of(req_type);
    assign illegal  = !type_legal(req_type, XLEN);
    assign misalign = !illegal && ((4'(req_off) & (st_size - 4'd1)) != 4'd0);

    for (genvar gi = 0; gi < NB; gi++) begin : g_be
        assign be[gi] = (4'(gi) >= 4'(req_off)) && (4'(gi) < 4'(req_off) + st_size);
    end

    // Replicating the low bytes puts them under whichever aligned lanes are enabled.
    always_comb begin
        wdata = req_wdata;
        case (st_size)
            4'd1:    wdata = {NB{req_wdata[7:0]}};
            4'd2:    wdata = {(NB/2){req_wdata[15:0]}};
            4'd4:    wdata = {(NB/4){req_wdata[31:0]}};
            default: wdata = req_wdata;
        endcase
    end

    assign ld_size   = size_of(ld_type);
    assign shifted   = rdata >> {ld_off, 3'b000};
    assign keep_mask = ~({XLEN{1'b1}} << {ld_size, 3'b000});
    assign do_sext   = (ld_type == DM_WORD) || (ld_type == DM_HALF) || (ld_type == DM_BYTE);

    always_comb begin
        sign_bit = 1'b0;
        case (ld_size)
            4'd1:    sign_bit = shifted[7];
            4'd2:    sign_bit = shifted[15];
            4'd4:    sign_bit = shifted[31];
            default: sign_bit = shifted[XLEN-1];
        endcase
    end

    assign ld_data = (shifted & keep_mask) | ((do_sext && sign_bit) ? ~keep_mask : '0);

endmodule

// File: rtl/mem_lsu.sv
// Multi-cycle load/store unit: checks a CPU access, issues one bus request with a
// bounded wait for ready, and returns extended load data with an error code.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [2:0]      req_type,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [1:0]      rsp_err,
    mem_lsu_if.master       bus
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            bus_req_reg, bus_req_next;
    logic            bus_we_reg, bus_we_next;
    logic [XLEN-1:0] bus_addr_reg, bus_addr_next;
    logic [NB-1:0]   bus_be_reg, bus_be_next;
    logic [XLEN-1:0] bus_wdata_reg, bus_wdata_next;
    logic [2:0]      ld_type_reg, ld_type_next;
    logic [LB-1:0]   ld_off_reg, ld_off_next;
    logic [XLEN-1:0] rdata_reg, rdata_next;
    err_e            err_reg, err_next;

    logic            lane_illegal;
    logic            lane_misalign;
    logic [NB-1:0]   lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_ld_data;

    mem_lsu_lane #(
        .XLEN(XLEN)
    ) u_lane (
        .req_type (req_type),
        .req_off  (req_addr[LB-1:0]),
        .req_wdata(req_wdata),
        .ld_type  (ld_type_reg),
        .ld_off   (ld_off_reg),
        .rdata    (bus.rdata),
        .illegal  (lane_illegal),
        .misalign (lane_misalign),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .ld_data  (lane_ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_be_reg    <= '0;
            bus_wdata_reg <= '0;
            ld_type_reg   <= '0;
            ld_off_reg    <= '0;
            rdata_reg     <= '0;
            err_reg       <= ERR_NONE;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_be_reg    <= bus_be_next;
            bus_wdata_reg <= bus_wdata_next;
            ld_type_reg   <= ld_type_next;
            ld_off_reg    <= ld_off_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_be_next    = bus_be_reg;
        bus_wdata_next = bus_wdata_reg;
        ld_type_next   = ld_type_reg;
        ld_off_next    = ld_off_reg;
        rdata_next     = rdata_reg;
        err_next       = err_reg;

        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (lane_illegal) begin
                        err_next   = ERR_TYPE;
                        rdata_next = '0;
                        state_next = RESP;
                    end else if (lane_misalign) begin
                        err_next   = ERR_MISALIGN;
                        rdata_next = '0;
                        state_next = RESP;
                    end else begin
                        bus_req_next   = 1'b1;
                        bus_we_next    = req_we;
                        bus_addr_next  = {req_addr[XLEN-1:LB], {LB{1'b0}}};
                        bus_be_next    = lane_be;
                        bus_wdata_next = req_we ? lane_wdata : '0;
                        ld_type_next   = req_type;
                        ld_off_next    = req_addr[LB-1:0];
                        cnt_next       = '0;
                        state_next     = BUS;
                    end
                end
            end
            BUS: begin
                // Ready is checked first so a last-cycle ready still completes cleanly.
                if (bus.ready) begin
                    bus_req_next = 1'b0;
                    err_next     = ERR_NONE;
                    rdata_next   = bus_we_reg ? '0 : lane_ld_data;
                    state_next   = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    bus_req_next = 1'b0;
                    err_next     = ERR_TIMEOUT;
                    rdata_next   = '0;
                    state_next   = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.req   = bus_req_reg;
    assign bus.we    = bus_we_reg;
    assign bus.addr  = bus_addr_reg;
    assign bus.be    = bus_be_reg;
    assign bus.wdata = bus_wdata_reg;

    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;
    assign stall     = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit and a 64-bit instance (TIMEOUT=4) driven
// one transaction at a time against hand-computed results.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v32 = 1'b0;
    logic        v64 = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = 3'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;

    logic        stall32, rv32, stall64, rv64;
    logic [31:0] rr32;
    logic [63:0] rr64;
    logic [1:0]  re32, re64;

    int total = 0;
    int bad = 0;

    logic [63:0] r_rdata, r_addr, r_wdata;
    logic [7:0]  r_be;
    logic [1:0]  r_err;
    int          r_lat, r_nbus;

    mem_lsu_if #(.XLEN(32)) b32 ();
    mem_lsu_if #(.XLEN(64)) b64 ();

    mem_lsu #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_we(req_we), .req_type(req_type),
        .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]), .stall(stall32),
        .rsp_valid(rv32), .rsp_rdata(rr32), .rsp_err(re32), .bus(b32)
    );

    mem_lsu #(.XLEN(64), .TIMEOUT(4)) dut64 (
        .clk(clk), .rst(rst), .req_valid(v64), .req_we(req_we), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall64),
        .rsp_valid(rv64), .rsp_rdata(rr64), .rsp_err(re64), .bus(b64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One access; the bus answers with rd and raises ready in BUS cycle rdy_at (-1: never).
    task automatic txn(input string name, input bit w64, input logic we, input logic [2:0] typ,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rd,
                       input int rdy_at);
        bit done;
        @(negedge clk);
        req_we = we; req_type = typ; req_addr = addr; req_wdata = wdata;
        b32.rdata = rd[31:0]; b64.rdata = rd;
        b32.ready = 1'b0; b64.ready = 1'b0;
        if (w64) v64 = 1'b1; else v32 = 1'b1;
        r_lat = 1; r_nbus = 0; done = 1'b0;
        r_rdata = '0; r_err = '0; r_addr = '0; r_be = '0; r_wdata = '0;
        #1 chk({name, "/stall_req"}, w64 ? stall64 : stall32, 1'b1);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            r_lat++;
            b32.ready = 1'b0; b64.ready = 1'b0;
            if (w64 ? rv64 : rv32) begin
                done = 1'b1;
                r_rdata = w64 ? rr64 : {32'd0, rr32};
                r_err = w64 ? re64 : re32;
                #1 chk({name, "/stall_rsp"}, w64 ? stall64 : stall32, 1'b0);
            end else if (w64 ? b64.req : b32.req) begin
                if (r_nbus == 0) begin
                    r_addr  = w64 ? b64.addr : {32'd0, b32.addr};
                    r_be    = w64 ? b64.be : {4'd0, b32.be};
                    r_wdata = w64 ? b64.wdata : {32'd0, b32.wdata};
                end
                if (r_nbus == rdy_at) begin
                    if (w64) b64.ready = 1'b1; else b32.ready = 1'b1;
                end
                r_nbus++;
            end
        end
        v32 = 1'b0; v64 = 1'b0; b32.ready = 1'b0; b64.ready = 1'b0;
        chk({name, "/rsp_seen"}, done, 1'b1);
        $display("txn %s: lat=%0d bus_cycles=%0d err=%0d rdata=0x%0h addr=0x%0h be=0x%0h wdata=0x%0h",
                 name, r_lat, r_nbus, r_err, r_rdata, r_addr, r_be, r_wdata);
    endtask

    initial begin
        b32.ready = 1'b0; b32.rdata = '0;
        b64.ready = 1'b0; b64.rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst/bus_req32", b32.req, 1'b0);
        chk("rst/bus_we32", b32.we, 1'b0);
        chk("rst/bus_addr32", b32.addr, 32'h0);
        chk("rst/bus_be32", b32.be, 4'h0);
        chk("rst/bus_wdata32", b32.wdata, 32'h0);
        chk("rst/rsp_valid32", rv32, 1'b0);
        chk("rst/rsp_rdata32", rr32, 32'h0);
        chk("rst/rsp_err32", re32, 2'd0);
        chk("rst/bus_req64", b64.req, 1'b0);
        chk("rst/rsp_valid64", rv64, 1'b0);
        rst = 1'b1;

        txn("sb", 1'b0, 1'b1, DM_BYTE, 64'h1003, 64'hAB, 64'h0, 0);
        chk("sb/addr", r_addr, 64'h1000);
        chk("sb/be", r_be, 8'h8);
        chk("sb/wdata", r_wdata, 64'hABABABAB);
        chk("sb/lat", r_lat, 3);
        chk("sb/nbus", r_nbus, 1);
        chk("sb/err", r_err, ERR_NONE);
        chk("sb/rdata", r_rdata, 64'h0);

        txn("lh", 1'b0, 1'b0, DM_HALF, 64'h2002, 64'h0, 64'h80011234, 0);
        chk("lh/rdata", r_rdata, 64'hFFFF8001);
        chk("lh/err", r_err, ERR_NONE);
        chk("lh/addr", r_addr, 64'h2000);

        txn("lhu", 1'b0, 1'b0, DM_HALF_U, 64'h2002, 64'h0, 64'h80011234, 0);
        chk("lhu/rdata", r_rdata, 64'h00008001);

        txn("lw_mis", 1'b0, 1'b0, DM_WORD, 64'h3002, 64'h0, 64'h0, 0);
        chk("lw_mis/err", r_err, ERR_MISALIGN);
        chk("lw_mis/lat", r_lat, 2);
        chk("lw_mis/nbus", r_nbus, 0);
        chk("lw_mis/rdata", r_rdata, 64'h0);

        txn("lw_to", 1'b0, 1'b0, DM_WORD, 64'h40, 64'h0, 64'h5555, -1);
        chk("lw_to/err", r_err, ERR_TIMEOUT);
        chk("lw_to/nbus", r_nbus, 4);
        chk("lw_to/lat", r_lat, 6);
        chk("lw_to/rdata", r_rdata, 64'h0);

        txn("lw_late", 1'b0, 1'b0, DM_WORD, 64'h44, 64'h0, 64'h12345678, 3);
        chk("lw_late/err", r_err, ERR_NONE);
        chk("lw_late/nbus", r_nbus, 4);
        chk("lw_late/rdata", r_rdata, 64'h12345678);
        chk("lw_late/addr", r_addr, 64'h44);

        txn("ld32", 1'b0, 1'b0, DM_DWORD, 64'h8, 64'h0, 64'h0, 0);
        chk("ld32/err", r_err, ERR_TYPE);
        chk("ld32/lat", r_lat, 2);
        chk("ld32/nbus", r_nbus, 0);

        txn("type6", 1'b0, 1'b0, 3'b110, 64'h8, 64'h0, 64'h0, 0);
        chk("type6/err", r_err, ERR_TYPE);

        txn("lb", 1'b0, 1'b0, DM_BYTE, 64'h5001, 64'h0, 64'h1234F078, 0);
        chk("lb/rdata", r_rdata, 64'hFFFFFFF0);

        txn("lbu", 1'b0, 1'b0, DM_BYTE_U, 64'h5003, 64'h0, 64'h1234F078, 0);
        chk("lbu/rdata", r_rdata, 64'h12);

        txn("sh", 1'b0, 1'b1, DM_HALF, 64'h6002, 64'hCAFE1234, 64'h0, 0);
        chk("sh/addr", r_addr, 64'h6000);
        chk("sh/be", r_be, 8'hC);
        chk("sh/wdata", r_wdata, 64'h12341234);

        txn("sw", 1'b0, 1'b1, DM_WORD, 64'h7000, 64'h11223344, 64'hFFFFFFFF, 1);
        chk("sw/be", r_be, 8'hF);
        chk("sw/wdata", r_wdata, 64'h11223344);
        chk("sw/err", r_err, ERR_NONE);
        chk("sw/rdata", r_rdata, 64'h0);
        chk("sw/lat", r_lat, 4);

        txn("ld64", 1'b1, 1'b0, DM_DWORD, 64'h8, 64'h0, 64'h0123456789ABCDEF, 0);
        chk("ld64/be", r_be, 8'hFF);
        chk("ld64/addr", r_addr, 64'h8);
        chk("ld64/rdata", r_rdata, 64'h0123456789ABCDEF);
        chk("ld64/err", r_err, ERR_NONE);
        chk("ld64/lat", r_lat, 3);

        txn("lw64", 1'b1, 1'b0, DM_WORD, 64'hC, 64'h0, 64'h8765432100000000, 0);
        chk("lw64/rdata", r_rdata, 64'hFFFFFFFF87654321);
        chk("lw64/addr", r_addr, 64'h8);

        txn("sb64", 1'b1, 1'b1, DM_BYTE, 64'h5, 64'h7F, 64'h0, 0);
        chk("sb64/be", r_be, 8'h20);
        chk("sb64/wdata", r_wdata, 64'h7F7F7F7F7F7F7F7F);

        txn("ld64_mis", 1'b1, 1'b0, DM_DWORD, 64'h4, 64'h0, 64'h0, 0);
        chk("ld64_mis/err", r_err, ERR_MISALIGN);

        // Reset pulled while the 32-bit unit waits in BUS.
        @(negedge clk);
        req_we = 1'b0; req_type = DM_WORD; req_addr = 64'h20; b32.ready = 1'b0; v32 = 1'b1;
        @(negedge clk);
        chk("rst_mid/in_bus", b32.req, 1'b1);
        #2 rst = 1'b0;
        #1 chk("rst_mid/req_async", b32.req, 1'b0);
        v32 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_mid/no_rsp", rv32, 1'b0);
        end
        rst = 1'b1;
        $display("txn rst_mid: reset asserted during BUS");

        txn("lw_after", 1'b0, 1'b0, DM_WORD, 64'h10, 64'h0, 64'hDEADBEEF, 0);
        chk("lw_after/rdata", r_rdata, 64'hDEADBEEF);
        chk("lw_after/err", r_err, ERR_NONE);
        chk("lw_after/lat", r_lat, 3);
        chk("lw_after/addr", r_addr, 64'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
